instruction_fetch: RTL and testbench

Program-side front end of the TTM4 emulator core: owns the program counter, fetches instruction words from a synchronous program ROM, and drives the OP/SR/LR fields consumed by `INSTRUCTION_DECODER`. It closes the loop from the decoder by acting on its sequencing controls (`nPC_LD`, `SPC`, `nSK_EN`, `SP_D_nU`) to update the PC. It also maintains a small hardware return stack.

---
 rtl/ttm4_pkg.sv | 34 +++
 rtl/call_stack.sv | 56 +++++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttm4_pkg.sv
// Shared TTM4 definitions: opcodes, IR field layout and fetch FSM encoding.
package ttm4_pkg;

  // Opcode values as they appear in IR[IW-1:IW-5]
  localparam logic [4:0] OP_MOV = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b10000;
  localparam logic [4:0] OP_XOR = 5'b10001;
  localparam logic [4:0] OP_OR  = 5'b10010;
  localparam logic [4:0] OP_ADD = 5'b10100;
  localparam logic [4:0] OP_SUB = 5'b10110;
  localparam logic [4:0] OP_CMP = 5'b10111;
  localparam logic [4:0] OP_POP = 5'b01000;
  localparam logic [4:0] OP_PSH = 5'b01001;
  localparam logic [4:0] OP_JNC = 5'b01010;
  localparam logic [4:0] OP_JC  = 5'b01011;
  localparam logic [4:0] OP_JMP = 5'b01100;
  localparam logic [4:0] OP_JNZ = 5'b01110;
  localparam logic [4:0] OP_JZ  = 5'b01111;

  // IR fields are packed from the MSB down: OP, SR, LR, then IMM fills the rest.
  localparam int unsigned OpW     = 5;
  localparam int unsigned SrW     = 3;
  localparam int unsigned LrW     = 3;
  localparam int unsigned OpOffs  = 0;              // bits below MSB
  localparam int unsigned SrOffs  = OpW;
  localparam int unsigned LrOffs  = OpW + SrW;
  localparam int unsigned FieldsW = OpW + SrW + LrW;

  typedef enum logic {
    StFetch = 1'b0,
    StExec  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/call_stack.sv
// Small LIFO of return addresses. Only the stack pointer is reset; entries above
// the pointer are never read, so the storage needs no reset.
module call_stack #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] data_i,
  output logic [AW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned SpW  = IdxW + 1;  // must hold 0..DEPTH

  logic [SpW-1:0]  sp_q, sp_d;
  logic [AW-1:0]   mem_q [DEPTH];
  logic [IdxW-1:0] wr_idx, rd_idx;

  assign full_o  = (sp_q == SpW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign wr_idx  = sp_q[IdxW-1:0];
  assign rd_idx  = IdxW'(sp_q - SpW'(1));
  assign top_o   = mem_q[rd_idx];

  // Pointer next state; push into a full stack or pop from an empty one is dropped
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  // Stack pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage, written at the current pointer on an accepted push
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// TTM4 front end: PC, fetch/execute sequencing, IR field split and return stack.
module instruction_fetch
  import ttm4_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  output logic [AW-1:0]  ROM_ADDR,
  input  logic [IW-1:0]  ROM_DATA,
  input  logic [AW-1:0]  PC_D,
  input  logic           nPC_LD,
  input  logic           SPC,
  input  logic           nSK_EN,
  input  logic           SP_D_nU,
  output logic [4:0]     OP,
  output logic [2:0]     SR,
  output logic [2:0]     LR,
  output logic [IW-12:0] IMM,
  output logic           EXEC,
  output logic [AW-1:0]  PC,
  output logic           STK_ERR
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          err_q, err_d;

  logic          exec_step;
  logic          push_req, pop_req;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] stk_top;
  logic          stk_full, stk_empty;

  // Decoder controls only count on the edge that leaves EXEC
  assign exec_step = (state_q == StExec) && EN;
  assign push_req  = exec_step && !nSK_EN && !SP_D_nU;
  assign pop_req   = exec_step && !nSK_EN && SP_D_nU;
  assign pc_inc    = pc_q + AW'(1);

  call_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_call_stack (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .data_i  (pc_inc),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // FSM next state, IR capture, next-PC priority and sticky stack error
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    if (EN) begin
      unique case (state_q)
        StFetch: begin
          ir_d    = ROM_DATA;
          state_d = StExec;
        end
        StExec: begin
          state_d = StFetch;
          if (pop_req) begin
            pc_d = stk_empty ? pc_inc : stk_top;
          end else if (SPC) begin
            pc_d = pc_q;
          end else if (!nPC_LD) begin
            pc_d = PC_D;
          end else begin
            pc_d = pc_inc;
          end
          if ((pop_req && stk_empty) || (push_req && stk_full)) begin
            err_d = 1'b1;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign ROM_ADDR = pc_q;
  assign PC       = pc_q;
  assign EXEC     = (state_q == StExec);
  assign STK_ERR  = err_q;
  assign OP       = ir_q[IW-1-OpOffs -: OpW];
  assign SR       = ir_q[IW-1-SrOffs -: SrW];
  assign LR       = ir_q[IW-1-LrOffs -: LrW];
  assign IMM      = ir_q[IW-1-FieldsW:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural program ROM.
module tb_instruction_fetch;
  import ttm4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_q;
  logic [7:0]  pc_d;
  logic        n_pc_ld, spc, n_sk_en, sp_d_nu;
  logic [4:0]  op;
  logic [2:0]  sr, lr;
  logic [4:0]  imm;
  logic        exec_o;
  logic [7:0]  pc;
  logic        stk_err;

  logic [15:0] rom [256];

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch #(
    .AW    (8),
    .IW    (16),
    .DEPTH (4)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .EN       (en),
    .ROM_ADDR (rom_addr),
    .ROM_DATA (rom_q),
    .PC_D     (pc_d),
    .nPC_LD   (n_pc_ld),
    .SPC      (spc),
    .nSK_EN   (n_sk_en),
    .SP_D_nU  (sp_d_nu),
    .OP       (op),
    .SR       (sr),
    .LR       (lr),
    .IMM      (imm),
    .EXEC     (exec_o),
    .PC       (pc),
    .STK_ERR  (stk_err)
  );

  always #10 clk = ~clk;

  // ROM output register clocked mid-cycle so the word for ROM_ADDR is ready at the next rise
  always @(negedge clk) rom_q <= rom[rom_addr];

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
    logic        n_pc_ld;
    logic        spc;
    logic        n_sk_en;
    logic        sp_d_nu;
    logic [7:0]  pc_d;
    logic [4:0]  op;
    logic [2:0]  sr;
    logic [2:0]  lr;
    logic [4:0]  imm;
    logic [7:0]  nxt;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_ctrl(input logic ld, input logic hold, input logic sk, input logic dir,
                          input logic [7:0] tgt);
    n_pc_ld = ld;
    spc     = hold;
    n_sk_en = sk;
    sp_d_nu = dir;
    pc_d    = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs one FETCH+EXEC pair from FETCH, applying controls during EXEC
  task automatic exec_instr(input logic ld, input logic hold, input logic sk, input logic dir,
                            input logic [7:0] tgt);
    @(posedge clk); #1;
    set_ctrl(ld, hold, sk, dir, tgt);
    @(posedge clk); #1;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 16'h0820, 1, 0, 1, 0, 8'h00, OP_MOV, 3'd0, 3'd1, 5'd0, 8'h01, 0};
    vecs[1]  = '{8'h01, 16'h8840, 1, 0, 1, 0, 8'h00, OP_XOR, 3'd0, 3'd2, 5'd0, 8'h02, 0};
    vecs[2]  = '{8'h02, 16'h8060, 1, 0, 1, 0, 8'h00, OP_AND, 3'd0, 3'd3, 5'd0, 8'h03, 0};
    vecs[3]  = '{8'h03, 16'h9000, 1, 0, 1, 0, 8'h00, OP_OR,  3'd0, 3'd0, 5'd0, 8'h04, 0};
    vecs[4]  = '{8'h04, 16'h6000, 0, 0, 1, 0, 8'h05, OP_JMP, 3'd0, 3'd0, 5'd0, 8'h05, 0};
    vecs[5]  = '{8'h05, 16'h6000, 0, 0, 1, 0, 8'h40, OP_JMP, 3'd0, 3'd0, 5'd0, 8'h40, 0};
    vecs[6]  = '{8'h40, 16'h6000, 0, 0, 1, 0, 8'h10, OP_JMP, 3'd0, 3'd0, 5'd0, 8'h10, 0};
    vecs[7]  = '{8'h10, 16'h4800, 0, 0, 0, 0, 8'h80, OP_PSH, 3'd0, 3'd0, 5'd0, 8'h80, 0};
    vecs[8]  = '{8'h80, 16'h0820, 1, 0, 1, 0, 8'h00, OP_MOV, 3'd0, 3'd1, 5'd0, 8'h81, 0};
    vecs[9]  = '{8'h81, 16'h4000, 1, 0, 0, 1, 8'h00, OP_POP, 3'd0, 3'd0, 5'd0, 8'h11, 0};
    vecs[10] = '{8'h11, 16'h0820, 1, 1, 1, 0, 8'h00, OP_MOV, 3'd0, 3'd1, 5'd0, 8'h11, 0};
    vecs[11] = '{8'h11, 16'h0820, 1, 1, 0, 1, 8'h00, OP_MOV, 3'd0, 3'd1, 5'd0, 8'h12, 1};
    vecs[12] = '{8'h12, 16'h6000, 0, 0, 1, 0, 8'hFF, OP_JMP, 3'd0, 3'd0, 5'd0, 8'hFF, 1};
    vecs[13] = '{8'hFF, 16'hBD25, 1, 0, 1, 0, 8'h00, OP_CMP, 3'd5, 3'd1, 5'd5, 8'h00, 1};

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 14; i++) rom[vecs[i].pc] = vecs[i].word;
    rom[8'h07] = 16'h8840;
    rom[8'h08] = 16'hBD25;
    rom[8'h22] = 16'h8840;

    // Reset values
    do_reset();
    check("rst_pc", pc, 8'h00);
    check("rst_rom_addr", rom_addr, 8'h00);
    check("rst_exec", exec_o, 1'b0);
    check("rst_op", op, 5'd0);
    check("rst_sr_lr_imm", {sr, lr, imm}, 11'd0);
    check("rst_stk_err", stk_err, 1'b0);

    // Table-driven program: sequential, jumps, call/return, hold, empty pop, wrap
    for (int i = 0; i < 14; i++) begin
      check($sformatf("v%0d_fetch_pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].pc);
      check($sformatf("v%0d_fetch_exec", i), exec_o, 1'b0);
      @(posedge clk); #1;
      check($sformatf("v%0d_exec", i), exec_o, 1'b1);
      check($sformatf("v%0d_op", i), op, vecs[i].op);
      check($sformatf("v%0d_sr", i), sr, vecs[i].sr);
      check($sformatf("v%0d_lr", i), lr, vecs[i].lr);
      check($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      check($sformatf("v%0d_exec_pc", i), pc, vecs[i].pc);
      set_ctrl(vecs[i].n_pc_ld, vecs[i].spc, vecs[i].n_sk_en, vecs[i].sp_d_nu, vecs[i].pc_d);
      @(posedge clk); #1;
      set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("v%0d_next_pc", i), pc, vecs[i].nxt);
      check($sformatf("v%0d_stk_err", i), stk_err, vecs[i].err);
    end

    // Hold with SPC, then freeze with EN low in EXEC
    do_reset();
    exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h07);
    check("hold_jump_pc", pc, 8'h07);
    for (int i = 0; i < 3; i++) begin
      exec_instr(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      check($sformatf("hold_pc_%0d", i), pc, 8'h07);
    end
    @(posedge clk); #1;
    check("step_op_before", op, OP_XOR);
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("step_op_frozen", op, OP_XOR);
    check("step_pc_frozen", pc, 8'h07);
    check("step_exec_frozen", exec_o, 1'b1);
    en = 1'b1;
    @(posedge clk); #1;
    check("step_resume_exec", exec_o, 1'b0);
    check("step_resume_pc", pc, 8'h08);
    @(posedge clk); #1;
    check("step_resume_op", op, OP_CMP);

    // Overflow: four pushes accepted, fifth dropped
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("push%0d_pc", i), pc, 8'(i + 1));
      check($sformatf("push%0d_err", i), stk_err, (i == 4) ? 1'b1 : 1'b0);
    end
    // Pops return 4,3,2,1 then the empty pop increments
    begin
      logic [7:0] exp_pc [5];
      exp_pc[0] = 8'h04; exp_pc[1] = 8'h03; exp_pc[2] = 8'h02; exp_pc[3] = 8'h01;
      exp_pc[4] = 8'h02;
      for (int i = 0; i < 5; i++) begin
        exec_instr(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check($sformatf("pop%0d_pc", i), pc, exp_pc[i]);
      end
    end

    // Empty pop straight after reset
    do_reset();
    check("empty_err_before", stk_err, 1'b0);
    exec_instr(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("empty_pop_pc", pc, 8'h01);
    check("empty_pop_err", stk_err, 1'b1);

    // Asynchronous reset in EXEC with a push pending
    do_reset();
    exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    check("mid_pc", pc, 8'h22);
    @(posedge clk); #1;
    check("mid_op", op, OP_XOR);
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_exec", exec_o, 1'b0);
    check("mid_rst_op", op, 5'd0);
    check("mid_rst_rom_addr", rom_addr, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    exec_instr(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("mid_no_push_pc", pc, 8'h01);
    check("mid_no_push_err", stk_err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
